// File: rtl/time_pkg.sv
// Shared constants, command encoding and BCD helpers for the clock
// time-unit counters and the display block.
package time_pkg;

   localparam int MOD_SEC     = 60;
   localparam int MOD_MIN     = 60;
   localparam int MOD_HR24    = 24;
   localparam int MOD_HR12    = 13;
   localparam int MIN_HR12    = 1;
   localparam int MIN_DEFAULT = 0;
   localparam int BCD_W       = 8;

   // One action per cycle, already resolved by priority.
   typedef enum logic [2:0] {
      CMD_HOLD,
      CMD_LOAD,
      CMD_REJECT,
      CMD_UP,
      CMD_DOWN,
      CMD_TICK
   } cmd_e;

   function automatic logic [6:0] bcd_to_bin(input logic [BCD_W-1:0] bcd);
      return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
   endfunction

   function automatic logic [BCD_W-1:0] bin_to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Single-bit rising-edge detector; history resets high so a level already
// asserted when reset releases does not look like a new edge.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) q <= 1'b1;
      else     q <= d;
   end

   assign rise = d & ~q;

endmodule

// File: rtl/bcd_time_counter.sv
// Two-digit BCD time-unit counter with run/set modes, parallel load and
// wrap carry; chain CARRY into the next stage's TICK.
module bcd_time_counter
   import time_pkg::*;
#(
   parameter int MODULUS = MOD_SEC,
   parameter int MIN_VAL = MIN_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             TICK,
   input  logic             SET,
   input  logic             INCR,
   input  logic             DECR,
   input  logic             LOAD,
   input  logic [BCD_W-1:0] LOAD_VAL,
   output logic [BCD_W-1:0] VALUE,
   output logic [6:0]       BIN,
   output logic             CARRY,
   output logic             LOAD_ERR
);

   localparam logic [BCD_W-1:0] MAX_BCD = bin_to_bcd(MODULUS - 1);
   localparam logic [BCD_W-1:0] MIN_BCD = bin_to_bcd(MIN_VAL);

   logic             inc_ev;
   logic             dec_ev;
   logic             at_max;
   logic             at_min;
   logic             load_ok;
   int               load_int;
   logic [BCD_W-1:0] inc_val;
   logic [BCD_W-1:0] dec_val;
   logic [BCD_W-1:0] value_d;
   logic             carry_d;
   logic             err_d;
   cmd_e             cmd;

   edge_rise u_inc_edge (.clk(CLK), .rst(RST), .d(INCR), .rise(inc_ev));
   edge_rise u_dec_edge (.clk(CLK), .rst(RST), .d(DECR), .rise(dec_ev));

   assign at_max = (VALUE == MAX_BCD);
   assign at_min = (VALUE == MIN_BCD);

   // Nibble range is checked first; bcd_to_bin is meaningless on non-BCD input.
   assign load_int = int'(bcd_to_bin(LOAD_VAL));
   assign load_ok  = (LOAD_VAL[7:4] <= 4'd9) && (LOAD_VAL[3:0] <= 4'd9) &&
                     (load_int >= MIN_VAL) && (load_int <= MODULUS - 1);

   assign inc_val = (VALUE[3:0] == 4'd9) ? {VALUE[7:4] + 4'd1, 4'd0}
                                         : {VALUE[7:4], VALUE[3:0] + 4'd1};
   assign dec_val = (VALUE[3:0] == 4'd0) ? {VALUE[7:4] - 4'd1, 4'd9}
                                         : {VALUE[7:4], VALUE[3:0] - 4'd1};

   // Priority: LOAD > set-mode adjust > run-mode TICK; RST is applied in the
   // register process. Edges seen in run mode are consumed without effect.
   always_comb begin
      cmd = CMD_HOLD;
      if (LOAD)                 cmd = load_ok ? CMD_LOAD : CMD_REJECT;
      else if (SET) begin
         if (inc_ev && !dec_ev) cmd = CMD_UP;
         else if (dec_ev && !inc_ev) cmd = CMD_DOWN;
      end
      else if (TICK)            cmd = CMD_TICK;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      value_d = VALUE;
      carry_d = 1'b0;
      err_d   = 1'b0;
      unique case (cmd)
         CMD_LOAD:   value_d = LOAD_VAL;
         CMD_REJECT: err_d   = 1'b1;
         CMD_UP:     value_d = at_max ? MIN_BCD : inc_val;
         CMD_DOWN:   value_d = at_min ? MAX_BCD : dec_val;
         CMD_TICK: begin
            value_d = at_max ? MIN_BCD : inc_val;
            carry_d = at_max;
         end
         default:    value_d = VALUE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         VALUE    <= MIN_BCD;
         CARRY    <= 1'b0;
         LOAD_ERR <= 1'b0;
      end else begin
         VALUE    <= value_d;
         CARRY    <= carry_d;
         LOAD_ERR <= err_d;
      end
   end

   assign BIN = bcd_to_bin(VALUE);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: a default (60,0) counter, a (13,1) counter and a chained
// pair of default counters, all on one clock.
module tb_bcd_time_counter;

   logic clk;
   int   total = 0;
   int   bad   = 0;

   // Instance A: default (60,0)
   logic       a_rst, a_tick, a_set, a_incr, a_decr, a_load;
   logic [7:0] a_load_val, a_value;
   logic [6:0] a_bin;
   logic       a_carry, a_err;

   // Instance B: 12 h hours (13,1)
   logic       b_rst, b_tick, b_set, b_incr, b_decr, b_load;
   logic [7:0] b_load_val, b_value;
   logic [6:0] b_bin;
   logic       b_carry, b_err;

   // Chain C: lo CARRY drives hi TICK
   logic       c_rst, c_tick, c_zero;
   logic [7:0] c_zero8, lo_value, hi_value;
   logic [6:0] lo_bin, hi_bin;
   logic       lo_carry, hi_carry, lo_err, hi_err;

   bcd_time_counter #(.MODULUS(60), .MIN_VAL(0)) u_a (
      .CLK(clk), .RST(a_rst), .TICK(a_tick), .SET(a_set), .INCR(a_incr),
      .DECR(a_decr), .LOAD(a_load), .LOAD_VAL(a_load_val), .VALUE(a_value),
      .BIN(a_bin), .CARRY(a_carry), .LOAD_ERR(a_err));

   bcd_time_counter #(.MODULUS(13), .MIN_VAL(1)) u_b (
      .CLK(clk), .RST(b_rst), .TICK(b_tick), .SET(b_set), .INCR(b_incr),
      .DECR(b_decr), .LOAD(b_load), .LOAD_VAL(b_load_val), .VALUE(b_value),
      .BIN(b_bin), .CARRY(b_carry), .LOAD_ERR(b_err));

   bcd_time_counter #(.MODULUS(60), .MIN_VAL(0)) u_lo (
      .CLK(clk), .RST(c_rst), .TICK(c_tick), .SET(c_zero), .INCR(c_zero),
      .DECR(c_zero), .LOAD(c_zero), .LOAD_VAL(c_zero8), .VALUE(lo_value),
      .BIN(lo_bin), .CARRY(lo_carry), .LOAD_ERR(lo_err));

   bcd_time_counter #(.MODULUS(60), .MIN_VAL(0)) u_hi (
      .CLK(clk), .RST(c_rst), .TICK(lo_carry), .SET(c_zero), .INCR(c_zero),
      .DECR(c_zero), .LOAD(c_zero), .LOAD_VAL(c_zero8), .VALUE(hi_value),
      .BIN(hi_bin), .CARRY(hi_carry), .LOAD_ERR(hi_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance n clocks, leaving time 1 ns past the edge for sampling/driving.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   int hi_carries;

   initial begin
      {a_tick, a_set, a_incr, a_decr, a_load} = '0;
      {b_tick, b_set, b_incr, b_decr, b_load} = '0;
      a_load_val = '0; b_load_val = '0;
      c_tick = 1'b0; c_zero = 1'b0; c_zero8 = '0;
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      cyc(2);
      a_rst = 1'b0; b_rst = 1'b0;

      // Reset state
      check("a_rst_val", a_value, 8'h00);
      check("a_rst_carry", a_carry, 1'b0);
      check("a_rst_err", a_err, 1'b0);
      check("b_rst_val", b_value, 8'h01);
      check("b_rst_bin", b_bin, 7'd1);

      // Test 1: 60 ticks, one carry on wrap to 00
      for (int i = 0; i < 60; i++) begin
         a_tick = 1'b1;
         cyc(1);
         check("t1_val", a_value, to_bcd((i + 1) % 60));
         check("t1_bin", a_bin, (i + 1) % 60);
         check("t1_carry", a_carry, (i == 59));
      end
      a_tick = 1'b0;
      cyc(1);
      check("t1_carry_drop", a_carry, 1'b0);
      check("t1_hold", a_value, 8'h00);

      // Test 2: (13,1) wrap and set-mode borrow wrap
      b_load_val = 8'h12; b_load = 1'b1; cyc(1); b_load = 1'b0;
      check("t2_load12", b_value, 8'h12);
      b_tick = 1'b1; cyc(1); b_tick = 1'b0;
      check("t2_wrap_val", b_value, 8'h01);
      check("t2_wrap_carry", b_carry, 1'b1);
      cyc(1);
      check("t2_carry_drop", b_carry, 1'b0);
      b_set = 1'b1; b_decr = 1'b1; cyc(1); b_decr = 1'b0;
      check("t2_dec_wrap", b_value, 8'h12);
      check("t2_dec_nocarry", b_carry, 1'b0);
      b_set = 1'b0;
      b_load_val = 8'h09; b_load = 1'b1; cyc(1); b_load = 1'b0;
      check("t2_load09", b_value, 8'h09);
      b_tick = 1'b1; cyc(1); b_tick = 1'b0;
      check("t2_bcd_tens", b_value, 8'h10);
      check("t2_bin10", b_bin, 7'd10);

      // Test 3: set mode on A (value 00)
      a_set = 1'b1; a_incr = 1'b1; cyc(10);
      check("t3_held_inc", a_value, 8'h01);
      a_incr = 1'b0; cyc(1);
      a_incr = 1'b1; a_decr = 1'b1; cyc(1);
      check("t3_both", a_value, 8'h01);
      a_incr = 1'b0; a_decr = 1'b0; cyc(1);
      a_tick = 1'b1; cyc(3);
      check("t3_tick_ign", a_value, 8'h01);
      check("t3_tick_nocarry", a_carry, 1'b0);
      a_tick = 1'b0;
      a_decr = 1'b1; cyc(1); a_decr = 1'b0;
      check("t3_dec", a_value, 8'h00);
      cyc(1);
      a_decr = 1'b1; cyc(1); a_decr = 1'b0;
      check("t3_dec_wrap", a_value, 8'h59);
      check("t3_dec_wrap_c", a_carry, 1'b0);
      a_incr = 1'b1; cyc(1); a_incr = 1'b0;
      check("t3_inc_wrap", a_value, 8'h00);
      check("t3_inc_wrap_c", a_carry, 1'b0);
      cyc(1);
      // Edge in run mode is consumed
      a_set = 1'b0; a_incr = 1'b1; cyc(1);
      check("t3_run_edge", a_value, 8'h00);
      a_set = 1'b1; cyc(1);
      check("t3_stale_edge", a_value, 8'h00);
      a_incr = 1'b0; a_set = 1'b0; cyc(1);

      // Test 4: load range checks
      a_load_val = 8'h5A; a_load = 1'b1; cyc(1); a_load = 1'b0;
      check("t4_5a_err", a_err, 1'b1);
      check("t4_5a_val", a_value, 8'h00);
      cyc(1);
      check("t4_err_drop", a_err, 1'b0);
      a_load_val = 8'h60; a_load = 1'b1; cyc(1); a_load = 1'b0;
      check("t4_60_err", a_err, 1'b1);
      check("t4_60_val", a_value, 8'h00);
      b_load_val = 8'h00; b_load = 1'b1; cyc(1); b_load = 1'b0;
      check("t4_b00_err", b_err, 1'b1);
      check("t4_b00_val", b_value, 8'h10);
      b_load_val = 8'h13; b_load = 1'b1; cyc(1); b_load = 1'b0;
      check("t4_b13_err", b_err, 1'b1);
      a_load_val = 8'h45; a_load = 1'b1; a_tick = 1'b1; cyc(1);
      a_load = 1'b0; a_tick = 1'b0;
      check("t4_45_val", a_value, 8'h45);
      check("t4_45_err", a_err, 1'b0);
      check("t4_45_carry", a_carry, 1'b0);
      a_set = 1'b1; a_incr = 1'b1; a_load_val = 8'h30; a_load = 1'b1; cyc(1);
      a_load = 1'b0; a_incr = 1'b0; a_set = 1'b0;
      check("t4_set_load", a_value, 8'h30);

      // Test 5: reset beats a wrap; button held through reset
      a_load_val = 8'h59; a_load = 1'b1; cyc(1); a_load = 1'b0;
      check("t5_load59", a_value, 8'h59);
      a_tick = 1'b1; a_rst = 1'b1; cyc(1); a_tick = 1'b0;
      check("t5_rst_val", a_value, 8'h00);
      check("t5_rst_carry", a_carry, 1'b0);
      a_set = 1'b1; a_incr = 1'b1; cyc(1);
      a_rst = 1'b0; cyc(3);
      check("t5_held_btn", a_value, 8'h00);
      a_incr = 1'b0; a_set = 1'b0;
      a_load_val = 8'h30; a_load = 1'b1; a_rst = 1'b1; cyc(1);
      a_load = 1'b0; a_rst = 1'b0;
      check("t5_rst_load", a_value, 8'h00);
      check("t5_rst_err", a_err, 1'b0);

      // Test 6: chained pair, 3600 ticks
      c_rst = 1'b0;
      hi_carries = 0;
      for (int i = 1; i <= 3600; i++) begin
         c_tick = 1'b1;
         cyc(1);
         if (hi_carry) hi_carries++;
         if (i == 3599) begin
            check("t6_lo59", lo_value, 8'h59);
            check("t6_hi59", hi_value, 8'h59);
         end
      end
      c_tick = 1'b0;
      check("t6_lo00", lo_value, 8'h00);
      cyc(1);
      if (hi_carry) hi_carries++;
      check("t6_hi00", hi_value, 8'h00);
      check("t6_hi_carry", hi_carry, 1'b1);
      cyc(1);
      if (hi_carry) hi_carries++;
      check("t6_hi_carries", hi_carries, 1);
      check("t6_lo_final", lo_value, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
